// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package addsub_pkg;

    // Operation select carried on in_op.
    typedef logic op_t;

    localparam op_t OP_ADD = 1'b0;
    localparam op_t OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; building block of the ripple slices.
// Latency: combinational.
// Backpressure: n/a.
// Ports: a, b, ci -> s (sum bit), co (carry out).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/ripple_chunk.sv
// CHUNK-bit ripple-carry adder slice built from full_adder cells.
// Latency: combinational.
// Backpressure: n/a.
// Ports: a, b, cin -> sum, cout (carry out of MSB), c_msb_in (carry into MSB,
//        needed by the most significant slice to derive signed overflow).
module ripple_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    // Each bit keeps its own carry nets so the chain is a plain series of
    // distinct wires rather than one vector feeding back into itself.
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic ci;
        logic co;

        if (i == 0) begin : g_first
            assign ci = cin;
        end else begin : g_next
            assign ci = g_bit[i-1].co;
        end

        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (ci),
            .s  (sum[i]),
            .co (co)
        );
    end

    assign cout     = g_bit[CHUNK-1].co;
    assign c_msb_in = g_bit[CHUNK-1].ci;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-bit ripple slice per stage, carry registered between slices.
// Latency: exactly STAGES cycles from accepted beat to out_valid when not stalled; one beat per cycle.
// Backpressure: global enable advance = out_ready | !out_valid freezes every stage; in_ready = advance.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_a/in_b/in_cin/in_op operand side;
//        out_valid/out_ready/out_sum/out_cout/out_ovf/out_zero result side.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int CHUNK = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_addsub: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign advance  = out_ready || !out_valid;
    assign in_ready = advance;

    // Subtraction as a + ~b + ~borrow_in; the raw carry-out then reads 1 = no borrow.
    assign b_eff = (in_op == OP_SUB) ? ~in_b : in_b;
    assign c0    = (in_op == OP_SUB) ? ~in_cin : in_cin;

    // Stage k consumes the low CHUNK bits of its operand view, so the operand
    // registers shrink by one slice per stage while the result skew register
    // grows by one slice. Nothing is carried that a later stage never reads.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = WIDTH - k * CHUNK;  // operand bits still to be summed
        localparam int SW = k * CHUNK;          // result bits already summed

        logic [IW-1:0]       sa;
        logic [IW-1:0]       sb;
        logic                sc;
        logic                sv;
        logic [CHUNK-1:0]    cs;
        logic                cc;
        logic [SW+CHUNK-1:0] sn;

        if (k == 0) begin : g_src
            assign sa = in_a;
            assign sb = b_eff;
            assign sc = c0;
            assign sv = in_valid;
            assign sn = cs;
        end else begin : g_src
            assign sa = g_stage[k-1].g_reg.a_q;
            assign sb = g_stage[k-1].g_reg.b_q;
            assign sc = g_stage[k-1].g_reg.c_q;
            assign sv = g_stage[k-1].g_reg.v_q;
            assign sn = {cs, g_stage[k-1].g_reg.s_q};
        end

        if (k < STAGES - 1) begin : g_reg
            logic [IW-CHUNK-1:0] a_q;
            logic [IW-CHUNK-1:0] b_q;
            logic [SW+CHUNK-1:0] s_q;
            logic                c_q;
            logic                v_q;

            ripple_chunk #(.CHUNK(CHUNK)) u_chunk (
                .a        (sa[CHUNK-1:0]),
                .b        (sb[CHUNK-1:0]),
                .cin      (sc),
                .sum      (cs),
                .cout     (cc),
                .c_msb_in ()
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                end else if (advance) begin
                    v_q <= sv;
                    a_q <= sa[IW-1:CHUNK];
                    b_q <= sb[IW-1:CHUNK];
                    s_q <= sn;
                    c_q <= cc;
                end
            end
        end else begin : g_out
            logic cm;

            ripple_chunk #(.CHUNK(CHUNK)) u_chunk (
                .a        (sa[CHUNK-1:0]),
                .b        (sb[CHUNK-1:0]),
                .cin      (sc),
                .sum      (cs),
                .cout     (cc),
                .c_msb_in (cm)
            );

            // Signed overflow: carry into the MSB disagrees with carry out of it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    out_sum   <= '0;
                    out_cout  <= 1'b0;
                    out_ovf   <= 1'b0;
                    out_zero  <= 1'b0;
                end else if (advance) begin
                    out_valid <= sv;
                    out_sum   <= sn;
                    out_cout  <= cc;
                    out_ovf   <= cm ^ cc;
                    out_zero  <= (sn == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench: directed vectors, back-pressure, mid-flight reset and a random parameter sweep.
// Latency: n/a.
// Backpressure: driven by the bench.
module tb_pipelined_addsub;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        op;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sw_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        out_zero;

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: integer arithmetic on w-bit values. ADD = a+b+cin, SUB = a-b-cin.
    // cout is the carry for ADD and "no borrow" for SUB; ovf means the true
    // signed result does not fit in w bits.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic op, input int w);
        res_t r;
        logic [65:0] mask, ua, ub, full;
        logic signed [65:0] sa, sb, sc, sr, smax, smin;
        mask = (66'(1) << w) - 66'(1);
        ua   = {2'b00, a} & mask;
        ub   = {2'b00, b} & mask;
        sc   = {65'b0, cin};
        if (!op) full = ua + ub + {65'b0, cin};
        else     full = ua - ub - {65'b0, cin};
        r.sum  = full[63:0] & mask[63:0];
        r.cout = op ? !full[65] : full[w];
        sa   = ua[w-1] ? (ua | ~mask) : ua;
        sb   = ub[w-1] ? (ub | ~mask) : ub;
        sr   = op ? (sa - sb - sc) : (sa + sb + sc);
        smax = mask >> 1;
        smin = ~smax;
        r.ovf  = (sr > smax) || (sr < smin);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a = v.a; in_b = v.b; in_cin = v.cin; in_op = v.op;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) in_valid = 1'b0;
            if (k == 3) chk($sformatf("vec%0d_early", idx), out_valid, 1'b0);
        end
        chk($sformatf("vec%0d_valid", idx), out_valid, 1'b1);
        chk($sformatf("vec%0d_result", idx), {out_sum, out_cout, out_ovf, out_zero},
            {v.sum, v.cout, v.ovf, v.zero});
    endtask

    initial begin
        sw_rst_n = 1'b0;
        #22 sw_rst_n = 1'b1;
    end

    // Random sweeps at other geometries, running alongside the directed tests.
    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : 64;
        localparam int S = (g == 0) ? 1 : (g == 1) ? 2 : 8;
        localparam int N = 10000;

        logic         iv, ir, ic, io, ov, orr, oc, oo, oz;
        logic [W-1:0] ia, ib, os;
        logic         done = 1'b0;

        pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk       (clk),
            .rst_n     (sw_rst_n),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_a      (ia),
            .in_b      (ib),
            .in_cin    (ic),
            .in_op     (io),
            .out_valid (ov),
            .out_ready (orr),
            .out_sum   (os),
            .out_cout  (oc),
            .out_ovf   (oo),
            .out_zero  (oz)
        );

        initial begin
            res_t q[$];
            res_t e;
            int   acc = 0;
            int   cyc = 0;
            iv = 1'b0; orr = 1'b0; ia = '0; ib = '0; ic = 1'b0; io = 1'b0;
            wait (sw_rst_n === 1'b1);
            while ((acc < N || q.size() > 0) && cyc < 60000) begin
                @(negedge clk);
                cyc++;
                iv = (acc < N) && ($urandom_range(3) != 0);
                case ($urandom_range(7))
                    0:       ia = '0;
                    1:       ia = '1;
                    default: ia = W'({$urandom, $urandom});
                endcase
                case ($urandom_range(7))
                    0:       ib = '0;
                    1:       ib = '1;
                    default: ib = W'({$urandom, $urandom});
                endcase
                ic  = 1'($urandom);
                io  = 1'($urandom);
                orr = ($urandom_range(3) != 0);
                #1;
                if (ov && orr) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sweep%0d_extra: unexpected beat %0h", W, os);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("sweep%0d_result", W), {os, oc, oo, oz},
                            {e.sum[W-1:0], e.cout, e.ovf, e.zero});
                    end
                end
                if (iv && ir) begin
                    q.push_back(model(64'(ia), 64'(ib), ic, io, W));
                    acc++;
                end
            end
            chk($sformatf("sweep%0d_accepted", W), acc, N);
            chk($sformatf("sweep%0d_left", W), q.size(), 0);
            done = 1'b1;
        end
    end

    initial begin
        vec_t vecs[10];
        res_t mq[$];
        res_t e;
        logic [34:0] held;
        int   sent, got, stale;
        bit   stalled_prev;

        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h0000_0005, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_op = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sum", out_sum, 32'h0);
        chk("rst_flags", {out_cout, out_ovf, out_zero}, 3'b000);
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with exact latency check
        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Back-pressure: 8 back-to-back beats, consumer stalls 5 cycles mid-stream
        sent = 0; got = 0; stalled_prev = 1'b0; held = '0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(negedge clk);
            in_valid  = (sent < 8);
            in_a      = $urandom;
            in_b      = $urandom;
            in_cin    = 1'($urandom);
            in_op     = 1'($urandom);
            out_ready = !(c >= 5 && c < 10);
            #1;
            if (out_valid && !out_ready) begin
                chk("bp_in_ready", in_ready, 1'b0);
                if (stalled_prev)
                    chk("bp_hold", {out_sum, out_cout, out_ovf, out_zero}, held);
                held = {out_sum, out_cout, out_ovf, out_zero};
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (mq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bp_extra: unexpected beat %0h", out_sum);
                end else begin
                    e = mq.pop_front();
                    chk($sformatf("bp_beat%0d", got), {out_sum, out_cout, out_ovf, out_zero},
                        {e.sum[31:0], e.cout, e.ovf, e.zero});
                end
                got++;
            end
            if (in_valid && in_ready) begin
                mq.push_back(model(64'(in_a), 64'(in_b), in_cin, in_op, 32));
                sent++;
            end
        end
        chk("bp_received", got, 8);
        chk("bp_left", mq.size(), 0);

        // Reset mid-flight: fill the pipe, then pulse rst_n between clock edges
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom); in_op = 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("rstmf_pre_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rstmf_valid", out_valid, 1'b0);
        chk("rstmf_outputs", {out_sum, out_cout, out_ovf, out_zero}, 35'h0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("rstmf_no_stale", stale, 0);
        run_vec(vecs[2], 100);

        // Wait for the random sweeps, bounded
        for (int t = 0; t < 90000; t++) begin
            if (g_sweep[0].done && g_sweep[1].done && g_sweep[2].done) break;
            @(negedge clk);
        end
        chk("sweep_done", {g_sweep[0].done, g_sweep[1].done, g_sweep[2].done}, 3'b111);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
